dvp_tx: RTL and testbench

- Camera-side DVP transmitter: turns a stream of RGB565 pixels into OV2640-style 8-bit byte-pair video (VSYNC, HREF, PIXDATA[9:2]), high byte first, one byte per clock.
- The same clock is exported as the pixel clock.
- Serves as an on-chip camera emulator and loopback source in front of the camera capture path and frame buffer. It is also the stimulus model for capture-path verification.

---
 rtl/dvp_pkg.sv | 33 +++
 rtl/dvp_timing_cnt.sv | 50 +++++
 rtl/dvp_tx.sv | 139 +++++++++++++
 tb/tb_dvp_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvp_pkg
// Brief    : Shared state encoding, byte phase and frame geometry helpers
//            for the DVP transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package dvp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VS     = 3'd1;
    localparam state_t ST_VBACK  = 3'd2;
    localparam state_t ST_ACTIVE = 3'd3;
    localparam state_t ST_VFRONT = 3'd4;

    // Byte phase is bit 0 of the horizontal counter inside the active span.
    localparam logic PH_HI = 1'b0;
    localparam logic PH_LO = 1'b1;

    function automatic int f_line_clks(input int h_res, input int h_blank);
        return 2 * h_res + h_blank;
    endfunction

    function automatic int f_frame_lines(input int vs_lines, input int v_back,
                                         input int v_res, input int v_front);
        return vs_lines + v_back + v_res + v_front;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_timing_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dvp_timing_cnt
// Brief    : Horizontal/vertical position counters with end-of-line and
//            end-of-frame pulses.
// Revision : 1.0 - initial release
// ============================================================================
module dvp_timing_cnt #(
    parameter int LINE_CLKS   = 784,
    parameter int FRAME_LINES = 510,
    parameter int HW          = 10,
    parameter int VW          = 9
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_adv,
    output logic [HW-1:0] O_h,
    output logic [VW-1:0] O_v,
    output logic          O_eol,
    output logic          O_eof
);

    localparam logic [HW-1:0] c_h_last = HW'(LINE_CLKS - 1);
    localparam logic [VW-1:0] c_v_last = VW'(FRAME_LINES - 1);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;

    assign O_eol = (r_h == c_h_last);
    assign O_eof = O_eol && (r_v == c_v_last);
    assign O_h   = r_h;
    assign O_v   = r_v;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (I_adv) begin
            if (O_eol) begin
                r_h <= '0;
                r_v <= O_eof ? '0 : r_v + VW'(1);
            end else begin
                r_h <= r_h + HW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : dvp_tx
// Brief    : DVP camera-side transmitter: RGB565 pixels out as byte pairs
//            with VSYNC/HREF framing, high byte first.
// Revision : 1.0 - initial release
// ============================================================================
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter int          H_BLANK  = 144,
    parameter int          VS_LINES = 3,
    parameter int          V_BACK   = 17,
    parameter int          V_FRONT  = 10,
    parameter int          VS_POL   = 0,
    parameter logic [15:0] FILL     = 16'h001F
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic [15:0] I_pix_data,
    input  logic        I_pix_valid,
    output logic        O_pix_rd,
    output logic        O_pixclk,
    output logic        O_vsync,
    output logic        O_href,
    output logic [9:0]  O_data,
    output logic        O_underrun,
    output logic [15:0] O_frame_cnt
);

    localparam int c_line  = f_line_clks(H_RES, H_BLANK);
    localparam int c_frame = f_frame_lines(VS_LINES, V_BACK, V_RES, V_FRONT);
    localparam int c_hw    = $clog2(c_line);
    localparam int c_vw    = (c_frame > 1) ? $clog2(c_frame) : 1;

    localparam logic [c_hw-1:0] c_h_act_last  = c_hw'(2 * H_RES - 1);
    localparam logic [c_vw-1:0] c_v_bk_start  = c_vw'(VS_LINES);
    localparam logic [c_vw-1:0] c_v_act_start = c_vw'(VS_LINES + V_BACK);
    localparam logic [c_vw-1:0] c_v_fr_start  = c_vw'(VS_LINES + V_BACK + V_RES);
    localparam logic            c_vs_on       = (VS_POL != 0);

    logic [c_hw-1:0] w_h;
    logic [c_vw-1:0] w_v;
    logic [c_vw-1:0] w_v_inc;
    logic            w_eol;
    logic            w_eof;
    logic            w_run;
    state_t          w_st;
    state_t          w_st_nxt;
    logic            w_act_byte;
    logic            w_rd_nxt;
    logic [15:0]     w_pix;

    state_t          r_state;
    logic [7:0]      r_lo;
    logic            r_eof_q;

    function automatic state_t f_region(input logic [c_vw-1:0] v);
        if (v < c_v_bk_start)       return ST_VS;
        else if (v < c_v_act_start) return ST_VBACK;
        else if (v < c_v_fr_start)  return ST_ACTIVE;
        else                        return ST_VFRONT;
    endfunction

    assign O_pixclk = I_clk;

    // Counters hold the position whose outputs are registered on the next edge.
    dvp_timing_cnt #(
        .LINE_CLKS   (c_line),
        .FRAME_LINES (c_frame),
        .HW          (c_hw),
        .VW          (c_vw)
    ) u_cnt (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_adv   (w_run),
        .O_h     (w_h),
        .O_v     (w_v),
        .O_eol   (w_eol),
        .O_eof   (w_eof)
    );

    always_comb begin
        w_run      = (r_state != ST_IDLE) || I_en;
        w_st       = (r_state == ST_IDLE) ? ST_VS : r_state;
        w_v_inc    = w_v + c_vw'(1);
        w_pix      = I_pix_valid ? I_pix_data : FILL;
        w_act_byte = w_run && (w_st == ST_ACTIVE) && (w_h <= c_h_act_last);
        w_st_nxt   = r_state;
        if (w_run) begin
            w_st_nxt = w_st;
            if (w_eol) begin
                if (w_eof) w_st_nxt = I_en ? ST_VS : ST_IDLE;
                else       w_st_nxt = f_region(w_v_inc);
            end
        end
        // Strobe one clock ahead of every high byte, including pixel 0 of a line.
        w_rd_nxt = w_run &&
                   (((w_st == ST_ACTIVE) && (w_h[0] == PH_LO) && (w_h < c_h_act_last)) ||
                    (w_eol && !w_eof && (f_region(w_v_inc) == ST_ACTIVE)));
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state     <= ST_IDLE;
            r_lo        <= '0;
            r_eof_q     <= 1'b0;
            O_vsync     <= ~c_vs_on;
            O_href      <= 1'b0;
            O_data      <= '0;
            O_pix_rd    <= 1'b0;
            O_underrun  <= 1'b0;
            O_frame_cnt <= '0;
        end else begin
            r_state  <= w_st_nxt;
            r_eof_q  <= w_run && w_eof;
            O_vsync  <= (w_run && (w_st == ST_VS)) ? c_vs_on : ~c_vs_on;
            O_href   <= w_act_byte;
            O_pix_rd <= w_rd_nxt;
            O_data   <= '0;
            if (r_eof_q) O_frame_cnt <= O_frame_cnt + 16'd1;
            if (w_act_byte) begin
                if (w_h[0] == PH_HI) begin
                    O_data <= {w_pix[15:8], 2'b00};
                    r_lo   <= w_pix[7:0];
                    if (!I_pix_valid) O_underrun <= 1'b1;
                end else begin
                    O_data <= {r_lo, 2'b00};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvp_tx
// Brief    : Directed self-checking bench for dvp_tx with a 14-clock line,
//            6-line frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, pix_valid, ur_mode;
    logic [15:0] pix_data;
    logic        pix_rd, pixclk, vsync, href, underrun;
    logic [9:0]  data;
    logic [15:0] frame_cnt;

    logic        rst_n1, en1;
    logic        pix_rd1, pixclk1, vsync1, href1, underrun1;
    logic [9:0]  data1;
    logic [15:0] frame_cnt1;

    int tests = 0;
    int fails = 0;
    int idx, strb_cnt;

    // Show-ahead source: pops only pixels it actually had.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 0;
            strb_cnt <= 0;
        end else begin
            if (pix_rd)              strb_cnt <= strb_cnt + 1;
            if (pix_rd && pix_valid) idx      <= idx + 1;
        end
    end
    assign pix_valid = !(ur_mode && (strb_cnt == 2));
    assign pix_data  = {8'(8'hA1 + 34 * idx), 8'(8'hB2 + 34 * idx)};

    dvp_tx #(.H_RES(4), .V_RES(3), .H_BLANK(6), .VS_LINES(1), .V_BACK(1),
             .V_FRONT(1), .VS_POL(0), .FILL(16'h001F)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_pix_data(pix_data),
        .I_pix_valid(pix_valid), .O_pix_rd(pix_rd), .O_pixclk(pixclk),
        .O_vsync(vsync), .O_href(href), .O_data(data), .O_underrun(underrun),
        .O_frame_cnt(frame_cnt));

    dvp_tx #(.H_RES(4), .V_RES(3), .H_BLANK(6), .VS_LINES(1), .V_BACK(1),
             .V_FRONT(1), .VS_POL(1), .FILL(16'h001F)) dut1 (
        .I_clk(clk), .I_rst_n(rst_n1), .I_en(en1), .I_pix_data(16'h5AA5),
        .I_pix_valid(1'b1), .O_pix_rd(pix_rd1), .O_pixclk(pixclk1),
        .O_vsync(vsync1), .O_href(href1), .O_data(data1), .O_underrun(underrun1),
        .O_frame_cnt(frame_cnt1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        en = 1'b0; ur_mode = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst_n1 = 1'b0; en = 1'b0; en1 = 1'b0; ur_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({vsync, href, data, pix_rd, underrun, frame_cnt} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL reset_vals: got vs=%b hr=%b d=%h rd=%b ur=%b fc=%0d want 1 0 000 0 0 0",
                     vsync, href, data, pix_rd, underrun, frame_cnt);
        end
        tests++;
        if (vsync1 !== 1'b0) begin
            fails++; $display("FAIL reset_vs_pol1: got %b want 0", vsync1);
        end
        tests++;
        if (pixclk !== clk) begin
            fails++; $display("FAIL pixclk: got %b want %b", pixclk, clk);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if ({vsync, href, pix_rd} !== 3'b100) begin
                fails++; $display("FAIL idle_hold c=%0d: got %b want 100", c, {vsync, href, pix_rd});
            end
        end
    endtask

    task automatic test_first_line;
        logic [13:0] exp, got;
        logic [7:0]  b;
        do_reset(); en = 1'b1;
        for (int c = 0; c < 36; c++) begin
            tick();
            b = 8'(8'hA1 + 17 * (c - 28));
            exp = {(c >= 14), (c >= 28), (c >= 28) ? {b, 2'b00} : 10'd0,
                   (c == 27 || c == 29 || c == 31 || c == 33)};
            got = {vsync, href, data, pix_rd};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL first_line c=%0d: got %h want %h", c, got, exp);
            end
        end
    endtask

    task automatic test_full_frame;
        int rd_n = 0, vs_n = 0, k = 0, rises = 0, len = 0;
        logic prev = 1'b0;
        logic [7:0] b;
        do_reset(); en = 1'b1;
        for (int c = 0; c <= 84; c++) begin
            tick();
            if (c < 84) begin
                rd_n += int'(pix_rd);
                vs_n += int'(!vsync);
            end
            if (href && !prev) begin
                tests++;
                if (c != 28 + 14 * rises) begin
                    fails++; $display("FAIL href_rise %0d: got c=%0d want c=%0d", rises, c, 28 + 14 * rises);
                end
                rises++; len = 0;
            end
            if (!href && prev) begin
                tests++;
                if (len != 8) begin
                    fails++; $display("FAIL href_len: got %0d want 8", len);
                end
            end
            if (href) begin
                len++;
                b = 8'(8'hA1 + 17 * k);
                tests++;
                if (data !== {b, 2'b00}) begin
                    fails++; $display("FAIL frame_byte %0d: got %h want %h", k, data, {b, 2'b00});
                end
                k++;
            end
            prev = href;
            if (c == 83) begin
                tests++;
                if (frame_cnt !== 16'd0) begin
                    fails++; $display("FAIL fcnt_c83: got %0d want 0", frame_cnt);
                end
            end
            if (c == 84) begin
                tests++;
                if ({frame_cnt, vsync} !== {16'd1, 1'b0}) begin
                    fails++; $display("FAIL fcnt_c84: got fc=%0d vs=%b want fc=1 vs=0", frame_cnt, vsync);
                end
            end
        end
        tests++;
        if (rd_n != 12) begin fails++; $display("FAIL rd_count: got %0d want 12", rd_n); end
        tests++;
        if (vs_n != 14) begin fails++; $display("FAIL vs_low_count: got %0d want 14", vs_n); end
        tests++;
        if (k != 24 || rises != 3) begin
            fails++; $display("FAIL href_total: got bytes=%0d runs=%0d want 24 3", k, rises);
        end
    endtask

    task automatic test_underrun;
        logic [7:0] tab [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h1F, 8'hE5, 8'hF6};
        logic [12:0] exp, got;
        do_reset(); ur_mode = 1'b1; en = 1'b1;
        for (int c = 0; c <= 84; c++) begin
            tick();
            if (c >= 26 && c < 36) begin
                exp = {(c >= 28), (c >= 28) ? {tab[(c >= 28) ? c - 28 : 0], 2'b00} : 10'd0,
                       (c == 27 || c == 29 || c == 31 || c == 33), (c >= 32)};
                got = {href, data, pix_rd, underrun};
                tests++;
                if (got !== exp) begin
                    fails++; $display("FAIL underrun_line c=%0d: got %h want %h", c, got, exp);
                end
            end
            if (c == 41 || c == 42) begin
                tests++;
                if (href !== (c == 42)) begin
                    fails++; $display("FAIL underrun_line1 c=%0d: got href=%b want %b", c, href, c == 42);
                end
            end
            if (c == 84) begin
                tests++;
                if ({underrun, vsync} !== 2'b10) begin
                    fails++; $display("FAIL underrun_sticky: got ur=%b vs=%b want 1 0", underrun, vsync);
                end
            end
        end
        ur_mode = 1'b0;
    endtask

    task automatic test_en_drop;
        int rd_n = 0;
        do_reset(); en = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            tick();
            if (c == 45) en = 1'b0;
            if (c < 84) rd_n += int'(pix_rd);
            if (c == 56) begin
                tests++;
                if (href !== 1'b1) begin fails++; $display("FAIL en_drop_line2: got href=%b want 1", href); end
            end
            if (c == 84) begin
                tests++;
                if (frame_cnt !== 16'd1) begin fails++; $display("FAIL en_drop_fcnt: got %0d want 1", frame_cnt); end
            end
            if (c >= 84) begin
                tests++;
                if ({vsync, href, pix_rd} !== 3'b100) begin
                    fails++; $display("FAIL en_drop_idle c=%0d: got %b want 100", c, {vsync, href, pix_rd});
                end
            end
        end
        tests++;
        if (rd_n != 12) begin fails++; $display("FAIL en_drop_rd: got %0d want 12", rd_n); end
    endtask

    task automatic test_async_reset;
        int vs_n = 0;
        do_reset(); en = 1'b1;
        for (int c = 0; c <= 30; c++) tick();
        tests++;
        if (href !== 1'b1) begin fails++; $display("FAIL pre_reset_href: got %b want 1", href); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({vsync, href, data, pix_rd, underrun, frame_cnt} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL async_reset: got vs=%b hr=%b d=%h rd=%b ur=%b fc=%0d want 1 0 000 0 0 0",
                     vsync, href, data, pix_rd, underrun, frame_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if (vsync !== 1'b1) begin fails++; $display("FAIL post_release_vs: got %b want 1", vsync); end
        for (int c = 0; c <= 28; c++) begin
            tick();
            if (c < 14) vs_n += int'(!vsync);
            if (c == 0 || c == 14) begin
                tests++;
                if (vsync !== (c == 14)) begin
                    fails++; $display("FAIL restart_vs c=%0d: got %b want %b", c, vsync, c == 14);
                end
            end
            if (c == 27 || c == 28) begin
                tests++;
                if ({href, data} !== ((c == 28) ? {1'b1, 8'hA1, 2'b00} : 11'd0)) begin
                    fails++; $display("FAIL restart_line c=%0d: got %b %h", c, href, data);
                end
            end
        end
        tests++;
        if (vs_n != 14) begin fails++; $display("FAIL restart_vs_len: got %0d want 14", vs_n); end
    endtask

    task automatic test_vs_pol;
        int hi_n = 0, bad = 0;
        @(negedge clk); rst_n1 = 1'b1; en1 = 1'b1;
        for (int c = 0; c <= 168; c++) begin
            tick();
            if (c < 84) hi_n += int'(vsync1);
            if (data1[1:0] !== 2'b00) bad++;
            if (c == 0 || c == 13 || c == 14 || c == 83 || c == 84 || c == 98) begin
                tests++;
                if (vsync1 !== (c == 0 || c == 13 || c == 84)) begin
                    fails++; $display("FAIL vspol c=%0d: got %b want %b", c, vsync1, (c == 0 || c == 13 || c == 84));
                end
            end
            if (c == 28 || c == 29) begin
                tests++;
                if (data1 !== ((c == 28) ? {8'h5A, 2'b00} : {8'hA5, 2'b00})) begin
                    fails++; $display("FAIL vspol_data c=%0d: got %h", c, data1);
                end
            end
            if (c == 168) begin
                tests++;
                if (frame_cnt1 !== 16'd2) begin fails++; $display("FAIL vspol_fcnt: got %0d want 2", frame_cnt1); end
            end
        end
        tests++;
        if (hi_n != 14) begin fails++; $display("FAIL vspol_len: got %0d want 14", hi_n); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL data_low_bits: got %0d nonzero want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_full_frame();
        test_underrun();
        test_en_drop();
        test_async_reset();
        test_vs_pol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
